// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder is reused for every operand bit, LSB first.
// The controller owns the operand shift registers, the carry flop, the bit
// counter and the start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// state | meaning
// IDLE  | waiting for a request
// RUN   | one operand bit added per cycle
// DONE  | single cycle, sum/cout freshly valid
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] a_sr_sh, b_sr_sh, res_nx;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             load, last_bit;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (state == RUN) && (cnt == CNT_LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // Next-state decode; load marks the edge that samples a new request.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          state_nx = RUN;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shift values for one RUN step; written as shifts so WIDTH=1 needs no special case.
  always_comb begin
    a_sr_sh = a_sr >> 1;
    b_sr_sh = b_sr >> 1;
    res_nx  = res_sr >> 1;
    res_nx[WIDTH-1] = fa_sum;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand/result shift registers, carry flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      res_sr  <= '0;
      carry_q <= cin;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sr    <= a_sr_sh;
      b_sr    <= b_sr_sh;
      res_sr  <= res_nx;
      carry_q <= fa_carry;
      cnt     <= cnt + CW'(1);
    end
  end

  // Result outputs only update on the edge that processes the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_bit) begin
      sum  <= res_nx;
      cout <= fa_carry;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a WIDTH=8 and a WIDTH=1 instance, both checked
// every cycle against a cycle-count model of the add, plus directed literals.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 0;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: an accepted request finishes exactly W edges later with the plain
  // arithmetic sum; index 0 is the WIDTH=8 instance, index 1 the WIDTH=1 one.
  int m_rem[2];
  int m_pend[2];
  int m_sum[2];
  int m_cout[2];
  int m_done[2];

  always @(posedge clk or posedge rst) begin
    int w[2];
    int st[2];
    int tot[2];
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i] = 0; m_pend[i] = 0; m_sum[i] = 0; m_cout[i] = 0; m_done[i] = 0;
      end
    end else begin
      w[0] = 8; w[1] = 1;
      st[0] = int'(start8); st[1] = int'(start1);
      tot[0] = int'(a8) + int'(b8) + int'(cin8);
      tot[1] = int'(a1) + int'(b1) + int'(cin1);
      for (int i = 0; i < 2; i++) begin
        if (m_rem[i] == 0 && st[i] != 0) begin
          m_rem[i]  = w[i];
          m_pend[i] = tot[i];
          m_done[i] = 0;
        end else if (m_rem[i] > 0) begin
          m_rem[i]--;
          m_done[i] = (m_rem[i] == 0) ? 1 : 0;
          if (m_rem[i] == 0) begin
            m_sum[i]  = m_pend[i] % (1 << w[i]);
            m_cout[i] = m_pend[i] >> w[i];
          end
        end else begin
          m_done[i] = 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", int'(busy8), (m_rem[0] > 0) ? 1 : 0);
      chk("done8", int'(done8), m_done[0]);
      chk("sum8",  int'(sum8),  m_sum[0]);
      chk("cout8", int'(cout8), m_cout[0]);
      chk("busy1", int'(busy1), (m_rem[1] > 0) ? 1 : 0);
      chk("done1", int'(done1), m_done[1]);
      chk("sum1",  int'(sum1),  m_sum[1]);
      chk("cout1", int'(cout1), m_cout[1]);
    end
  end

  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     output int acc);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic go1(input logic av, input logic bv, input logic cv, output int acc);
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Wait for done on the selected instance, then check latency and result literals.
  task automatic wait_done(input int w, input int acc, input int es, input int ec,
                           input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if ((w == 8) ? done8 : done1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_lat"}, cyc - acc, w);
      chk({nm, "_sum"}, (w == 8) ? int'(sum8) : int'(sum1), es);
      chk({nm, "_cout"}, (w == 8) ? int'(cout8) : int'(cout1), ec);
    end
  endtask

  initial begin
    int acc, acc2, d1, d2;
    rst = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_sum",  int'(sum8),  0);
    chk("rst_cout", int'(cout8), 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    go8(8'h5A, 8'h33, 1'b0, acc);
    wait_done(8, acc, 'h8D, 0, "add_5a_33");
    go8(8'hFF, 8'h01, 1'b0, acc);
    wait_done(8, acc, 'h00, 1, "add_ff_01");
    go8(8'hFF, 8'h00, 1'b1, acc);
    wait_done(8, acc, 'h00, 1, "add_ff_cin");

    // start pulses during RUN must be ignored
    go8(8'h10, 8'h20, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'hAA; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(8, acc, 'h30, 0, "ign_start");
    @(negedge clk);
    chk("single_done", int'(done8), 0);

    // reset mid-RUN clears the previous result
    go8(8'h01, 8'h01, 1'b0, acc);
    wait_done(8, acc, 'h02, 0, "add_01_01");
    go8(8'h7F, 8'h7F, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sum",  int'(sum8),  0);
    chk("abort_cout", int'(cout8), 0);
    chk("abort_busy", int'(busy8), 0);
    @(negedge clk);
    rst = 1'b0;
    go8(8'h03, 8'h04, 1'b0, acc);
    wait_done(8, acc, 'h07, 0, "add_03_04");

    // start held high: second RUN begins on the DONE cycle
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    wait_done(8, acc, 'h10, 0, "b2b_first");
    d1 = cyc;
    a8 = 8'hF0; b8 = 8'h10; cin8 = 1'b0;
    acc2 = cyc + 1;
    @(negedge clk);
    wait_done(8, acc2, 'h00, 1, "b2b_second");
    d2 = cyc;
    start8 = 1'b0;
    chk("b2b_gap", d2 - d1, 9);

    // WIDTH=1: every operand combination
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      go1(v[2], v[1], v[0], acc);
      wait_done(1, acc, (int'(v[2]) + int'(v[1]) + int'(v[0])) % 2,
                (int'(v[2]) + int'(v[1]) + int'(v[0])) / 2, "w1_combo");
    end

    // random traffic on both instances, checked by the model every cycle
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 3) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      start1 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      if (k == 300) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    start1 = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
